// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - opcodes, word fields and FSM encoding for the fetch unit
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_MV  = 3'b110,
    OP_MVI = 3'b111
  } opcode_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int RX_HI  = 12;
  localparam int RX_LO  = 10;
  localparam int RY_HI  = 9;
  localparam int RY_LO  = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_I    = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_WAIT_IMM  = 3'd4,
    S_ISSUE     = 3'd5,
    S_EXEC      = 3'd6,
    S_FINISH    = 3'd7
  } fsm_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program sequencer feeding the 16-bit core from a synchronous ROM
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int         AW      = 4,
  parameter int         TIMEOUT = 16,
  parameter logic [2:0] OPC_MVI = OP_MVI
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [15:0]   mem_data,
  output logic [15:0]   din,
  output logic          run,
  input  logic          done,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished,
  output logic          fault,
  output logic [15:0]   instr_count
);

  localparam int            TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  fsm_state_t    state, state_next;
  logic [15:0]   word, imm;
  logic [TW-1:0] timer;
  logic [AW-1:0] pc_plus1, last_word;
  logic          word_mvi, fetched_mvi, timer_expired;

  assign pc_plus1      = pc + AW'(1);
  assign word_mvi      = (word[OPC_HI:OPC_LO] == OPC_MVI);
  assign fetched_mvi   = (mem_data[OPC_HI:OPC_LO] == OPC_MVI);
  assign last_word     = word_mvi ? pc_plus1 : pc;
  assign timer_expired = (timer == TIMER_LAST);

  assign mem_rd   = (state == S_FETCH) || (state == S_FETCH_IMM);
  assign mem_addr = (state == S_FETCH_IMM) ? pc_plus1 : pc;
  assign run      = (state == S_ISSUE);
  assign busy     = (state != S_IDLE) && (state != S_FINISH);
  assign finished = (state == S_FINISH);

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_FINISH: if (start) state_next = S_FETCH;
      S_FETCH:          state_next = S_WAIT_I;
      S_WAIT_I: begin
        if (fetched_mvi) state_next = (pc == last_addr) ? S_FINISH : S_FETCH_IMM;
        else             state_next = S_ISSUE;
      end
      S_FETCH_IMM:      state_next = S_WAIT_IMM;
      S_WAIT_IMM:       state_next = S_ISSUE;
      S_ISSUE:          state_next = S_EXEC;
      S_EXEC: begin
        // done has priority over a timeout landing on the same cycle
        if (done)               state_next = (last_word >= last_addr) ? S_FINISH : S_FETCH;
        else if (timer_expired) state_next = S_FINISH;
      end
      default:          state_next = S_IDLE;
    endcase
  end

  // din is loaded one edge ahead so the core sees the opcode word on the run cycle
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc          <= '0;
      word        <= '0;
      imm         <= '0;
      timer       <= '0;
      din         <= '0;
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            fault       <= 1'b0;
          end
        end
        S_WAIT_I: begin
          word <= mem_data;
          if (fetched_mvi && (pc == last_addr)) fault <= 1'b1;
          if (!fetched_mvi) din <= mem_data;
        end
        S_WAIT_IMM: begin
          imm <= mem_data;
          din <= word;
        end
        S_ISSUE: begin
          timer <= '0;
          din   <= word_mvi ? imm : word;
        end
        S_EXEC: begin
          timer <= timer + TW'(1);
          if (done) begin
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            pc <= word_mvi ? pc + AW'(2) : pc_plus1;
          end else if (timer_expired) begin
            fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit with ROM model and core stub
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  last_addr = '0;
  logic [3:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic [15:0] din;
  logic        run;
  logic        done;
  logic [3:0]  pc;
  logic        busy, finished, fault;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_fail = 0;

  instr_fetch_unit #(.AW(4), .TIMEOUT(16), .OPC_MVI(3'b111)) dut (
    .clock(clock), .resetn(resetn), .start(start), .last_addr(last_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .din(din),
    .run(run), .done(done), .pc(pc), .busy(busy), .finished(finished),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  logic [15:0] rom [16];
  logic [15:0] rom_q = '0;
  always @(posedge clock) if (mem_rd) rom_q <= rom[mem_addr];
  assign mem_data = rom_q;

  // core stub: done asserted done_delay cycles after run; 0 = never
  int         done_delay = 2;
  logic [7:0] dcnt = '0;
  always @(posedge clock) begin
    if (!resetn)         dcnt <= '0;
    else if (run)        dcnt <= 8'd1;
    else if (done)       dcnt <= '0;
    else if (dcnt != 0)  dcnt <= dcnt + 8'd1;
  end
  assign done = (done_delay != 0) && (dcnt == 8'(done_delay));

  logic [15:0] runs_din[$];
  logic [15:0] after_din[$];
  int first_run, fault_at;
  bit timed_out;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic run_prog(input int max_cyc, input int glitch_after_run);
    bit prev_run = 1'b0;
    runs_din.delete();
    after_din.delete();
    first_run = -1;
    fault_at  = -1;
    timed_out = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      start = 1'b0;
      if (prev_run) after_din.push_back(din);
      if (run) begin
        runs_din.push_back(din);
        if (first_run < 0) first_run = c;
      end
      if (fault && fault_at < 0) fault_at = c;
      prev_run = run;
      if (finished) begin
        timed_out = 1'b0;
        break;
      end
      if (glitch_after_run > 0 && first_run > 0 && c == first_run + glitch_after_run) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_cmp++; if ({run, busy, finished, fault, mem_rd} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {run, busy, finished, fault, mem_rd}); end
    n_cmp++; if ({din, instr_count, pc, mem_addr} !== 40'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {din, instr_count, pc, mem_addr}); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_two_words();
    clear_rom();
    rom[0] = 16'hC280; rom[1] = 16'h0280;
    last_addr = 4'd1; done_delay = 2;
    run_prog(100, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL two_words_timeout: got %0d want 0", timed_out); end
    n_cmp++; if (first_run !== 3) begin n_fail++; $display("FAIL two_words_latency: got %0d want 3", first_run); end
    n_cmp++; if (runs_din.size() !== 2) begin n_fail++; $display("FAIL two_words_runs: got %0d want 2", runs_din.size()); end
    else begin
      n_cmp++; if (runs_din[0] !== 16'hC280) begin n_fail++; $display("FAIL two_words_din0: got %h want c280", runs_din[0]); end
      n_cmp++; if (runs_din[1] !== 16'h0280) begin n_fail++; $display("FAIL two_words_din1: got %h want 0280", runs_din[1]); end
    end
    n_cmp++; if ({instr_count, pc} !== {16'd2, 4'd2}) begin n_fail++; $display("FAIL two_words_count_pc: got %0d/%0d want 2/2", instr_count, pc); end
    n_cmp++; if ({finished, fault, busy} !== 3'b100) begin n_fail++; $display("FAIL two_words_flags: got %b want 100", {finished, fault, busy}); end
  endtask

  task automatic test_mvi();
    clear_rom();
    rom[0] = 16'hE180; rom[1] = 16'h0005;
    last_addr = 4'd1; done_delay = 3;
    run_prog(100, 0);
    n_cmp++; if (first_run !== 5) begin n_fail++; $display("FAIL mvi_latency: got %0d want 5", first_run); end
    n_cmp++; if (runs_din.size() !== 1 || runs_din[0] !== 16'hE180) begin n_fail++; $display("FAIL mvi_issue_din: got %0d runs want 1 with e180", runs_din.size()); end
    n_cmp++; if (after_din.size() !== 1 || after_din[0] !== 16'h0005) begin n_fail++; $display("FAIL mvi_imm_din: got %0d samples want 1 with 0005", after_din.size()); end
    n_cmp++; if (din !== 16'h0005) begin n_fail++; $display("FAIL mvi_din_hold: got %h want 0005", din); end
    n_cmp++; if ({instr_count, pc, fault, finished} !== {16'd1, 4'd2, 1'b0, 1'b1}) begin n_fail++; $display("FAIL mvi_end: got cnt %0d pc %0d fault %b fin %b want 1 2 0 1", instr_count, pc, fault, finished); end
  endtask

  task automatic test_mvi_truncated();
    clear_rom();
    rom[0] = 16'hE180;
    last_addr = 4'd0; done_delay = 2;
    run_prog(40, 0);
    n_cmp++; if (fault_at !== 3) begin n_fail++; $display("FAIL trunc_fault_cycle: got %0d want 3", fault_at); end
    n_cmp++; if (runs_din.size() !== 0) begin n_fail++; $display("FAIL trunc_no_run: got %0d runs want 0", runs_din.size()); end
    n_cmp++; if ({finished, fault, instr_count} !== {1'b1, 1'b1, 16'd0}) begin n_fail++; $display("FAIL trunc_flags: got fin %b fault %b cnt %0d want 1 1 0", finished, fault, instr_count); end
  endtask

  task automatic test_timeout();
    clear_rom();
    rom[0] = 16'h0280;
    last_addr = 4'd0; done_delay = 0;
    run_prog(80, 0);
    // run cycle, then 16 EXEC cycles, fault visible in the following cycle
    n_cmp++; if (fault_at - first_run !== 17) begin n_fail++; $display("FAIL timeout_delay: got %0d want 17", fault_at - first_run); end
    n_cmp++; if ({finished, fault, instr_count, pc} !== {1'b1, 1'b1, 16'd0, 4'd0}) begin n_fail++; $display("FAIL timeout_state: got fin %b fault %b cnt %0d pc %0d want 1 1 0 0", finished, fault, instr_count, pc); end
  endtask

  task automatic test_reset_mid_exec();
    int guard = 0;
    clear_rom();
    rom[0] = 16'hC280; rom[1] = 16'h0280;
    last_addr = 4'd1; done_delay = 2;
    start = 1'b1; tick(); start = 1'b0;
    while (!(run && pc == 4'd1) && guard < 50) begin tick(); guard++; end
    n_cmp++; if (guard >= 50) begin n_fail++; $display("FAIL rst_reach_second: got %0d cycles want <50", guard); end
    tick();
    n_cmp++; if ({instr_count, din} !== {16'd1, 16'h0280}) begin n_fail++; $display("FAIL rst_pre_state: got %0d %h want 1 0280", instr_count, din); end
    resetn = 1'b0;
    tick();
    n_cmp++; if ({run, busy, din, pc, instr_count} !== 38'h0) begin n_fail++; $display("FAIL rst_mid_exec: got run %b busy %b din %h pc %0d cnt %0d want all 0", run, busy, din, pc, instr_count); end
    resetn = 1'b1;
    tick();
    run_prog(100, 0);
    n_cmp++; if (runs_din.size() !== 2 || runs_din[0] !== 16'hC280) begin n_fail++; $display("FAIL rst_restart_runs: got %0d runs want 2 from c280", runs_din.size()); end
    n_cmp++; if ({instr_count, pc, fault} !== {16'd2, 4'd2, 1'b0}) begin n_fail++; $display("FAIL rst_restart_end: got cnt %0d pc %0d fault %b want 2 2 0", instr_count, pc, fault); end
  endtask

  task automatic test_start_busy_and_coincident();
    clear_rom();
    rom[0] = 16'h4280;
    last_addr = 4'd0; done_delay = 16;
    run_prog(80, 3);
    n_cmp++; if (runs_din.size() !== 1) begin n_fail++; $display("FAIL coinc_runs: got %0d want 1", runs_din.size()); end
    n_cmp++; if ({fault, finished, instr_count, pc} !== {1'b0, 1'b1, 16'd1, 4'd1}) begin n_fail++; $display("FAIL coinc_end: got fault %b fin %b cnt %0d pc %0d want 0 1 1 1", fault, finished, instr_count, pc); end
  endtask

  task automatic test_full_range_wrap();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0280 + 16'(i);
    last_addr = 4'd15; done_delay = 1;
    run_prog(400, 0);
    n_cmp++; if (runs_din.size() !== 16) begin n_fail++; $display("FAIL wrap_runs: got %0d want 16", runs_din.size()); end
    else begin
      n_cmp++; if (runs_din[15] !== 16'h028F) begin n_fail++; $display("FAIL wrap_last_din: got %h want 028f", runs_din[15]); end
    end
    n_cmp++; if ({instr_count, pc, fault, finished} !== {16'd16, 4'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL wrap_end: got cnt %0d pc %0d fault %b fin %b want 16 0 0 1", instr_count, pc, fault, finished); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_two_words();
    test_mvi();
    test_mvi_truncated();
    test_timeout();
    test_reset_mid_exec();
    test_start_busy_and_coincident();
    test_full_range_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
